// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider living in the execute stage.
//
// Implements DIV, DIVU, REM and REMU with a restoring, one-bit-per-cycle
// datapath. Divide-by-zero and signed overflow are resolved at start and skip
// the iteration entirely. While a division is being accepted or computed the
// unit asks the front of the pipeline to hold; the result retires with a
// single-cycle write-enable pulse.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-low reset
//   start_i     EX holds a divide instruction
//   op_i        funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i  rs1 value
//   divisor_i   rs2 value
//   rd_addr_i   destination register
//   flush_i     jump/flush from EX, cancels any in-flight division
//   busy_o      hold request to pipeline control (combinational)
//   ready_o     result valid, one-cycle pulse
//   result_o    quotient or remainder, holds after retirement
//   rd_addr_o   write-back destination, holds after retirement
//   reg_wen_o   write enable, identical to ready_o
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_addr_o,
  output logic             reg_wen_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // State and datapath registers
  state_e           r_state;
  logic             r_rem_sel;   // op_i[1]: 1 selects remainder
  logic             r_neg_q;     // negate quotient at the end
  logic             r_neg_r;     // negate remainder at the end
  logic [WIDTH-1:0] r_quot;      // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH:0]   r_rem;       // partial remainder, one spare bit for the trial
  logic [WIDTH-1:0] r_divisor;
  logic [CntW-1:0]  r_cnt;
  logic [4:0]       r_rd_pend;   // destination of the division in flight
  logic             r_ready;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_rd_addr;

  // Next-state values
  state_e           w_state_nxt;
  logic             w_rem_sel_nxt;
  logic             w_neg_q_nxt;
  logic             w_neg_r_nxt;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_divisor_nxt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic [4:0]       w_rd_pend_nxt;
  logic             w_ready_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [4:0]       w_rd_addr_nxt;

  // Start decode. funct3 values 0xx are multiplies and never belong here.
  logic             w_accept;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sc_quot;
  logic [WIDTH-1:0] w_sc_rem;

  assign w_accept   = (r_state == StIdle) && start_i && !flush_i && op_i[2];
  assign w_signed   = ~op_i[0];
  assign w_a_neg    = w_signed & dividend_i[WIDTH-1];
  assign w_b_neg    = w_signed & divisor_i[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_abs    = w_b_neg ? -divisor_i : divisor_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_signed && (dividend_i == MinInt) && (divisor_i == '1);
  // Divide-by-zero takes priority; the overflow case can never have a zero divisor.
  assign w_sc_quot  = w_div_zero ? '1 : MinInt;
  assign w_sc_rem   = w_div_zero ? dividend_i : '0;

  // One restoring step. The trial is two bits wider than the divisor so its
  // top bit is a clean borrow flag even when the shifted remainder uses the
  // spare bit.
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_step;
  logic [WIDTH-1:0] w_quot_step;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_diff      = w_shift - {2'b00, r_divisor};
  assign w_fits      = ~w_diff[WIDTH+1];
  assign w_rem_step  = w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign w_quot_step = {r_quot[WIDTH-2:0], w_fits};
  assign w_quot_fix  = r_neg_q ? -w_quot_step : w_quot_step;
  assign w_rem_fix   = r_neg_r ? -w_rem_step[WIDTH-1:0] : w_rem_step[WIDTH-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_rem_sel_nxt = r_rem_sel;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_quot_nxt    = r_quot;
    w_rem_nxt     = r_rem;
    w_divisor_nxt = r_divisor;
    w_cnt_nxt     = r_cnt;
    w_rd_pend_nxt = r_rd_pend;
    w_ready_nxt   = 1'b0;
    w_result_nxt  = r_result;
    w_rd_addr_nxt = r_rd_addr;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_rem_sel_nxt = op_i[1];
          w_neg_q_nxt   = w_a_neg ^ w_b_neg;
          w_neg_r_nxt   = w_a_neg;
          w_quot_nxt    = w_a_abs;
          w_rem_nxt     = '0;
          w_divisor_nxt = w_b_abs;
          w_cnt_nxt     = '0;
          w_rd_pend_nxt = rd_addr_i;
          if (w_div_zero || w_ovf) begin
            // Architecturally defined results: retire next cycle.
            w_state_nxt   = StDone;
            w_ready_nxt   = 1'b1;
            w_result_nxt  = op_i[1] ? w_sc_rem : w_sc_quot;
            w_rd_addr_nxt = rd_addr_i;
          end else begin
            w_state_nxt = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          w_state_nxt = StIdle;
        end else begin
          w_quot_nxt = w_quot_step;
          w_rem_nxt  = w_rem_step;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            // Last step: sign-correct the freshly computed values on the way in.
            w_state_nxt   = StDone;
            w_ready_nxt   = 1'b1;
            w_result_nxt  = r_rem_sel ? w_rem_fix : w_quot_fix;
            w_rd_addr_nxt = r_rd_pend;
          end
        end
      end
      StDone: begin
        // A start seen here belongs to the instruction behind; it is re-presented in idle.
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_rd_pend <= '0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem_sel <= w_rem_sel_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_quot    <= w_quot_nxt;
      r_rem     <= w_rem_nxt;
      r_divisor <= w_divisor_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_ready   <= w_ready_nxt;
      r_result  <= w_result_nxt;
      r_rd_addr <= w_rd_addr_nxt;
    end
  end

  // Busy stays low in done so the pipeline advances as the result retires.
  assign busy_o    = w_accept || (r_state == StCalc);
  // r_ready is only ever set while in done; a flush there kills the write-back.
  assign ready_o   = r_ready & ~flush_i;
  assign reg_wen_o = ready_o;
  assign result_o  = r_result;
  assign rd_addr_o = r_rd_addr;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o),
    .reg_wen_o (reg_wen_o)
  );

  localparam logic [2:0] OpDiv  = 3'b100;
  localparam logic [2:0] OpDivu = 3'b101;
  localparam logic [2:0] OpRem  = 3'b110;
  localparam logic [2:0] OpRemu = 3'b111;

  // Drives one divide, holding start_i like a stalled ID/EX until the result
  // retires. Called and returns just after a rising edge.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic seen, output logic [31:0] res,
                         output logic [4:0] rdo, output int busy_n, output int rdy_idx,
                         output int wen_bad);
    seen = 1'b0; res = '0; rdo = '0; busy_n = 0; rdy_idx = -1; wen_bad = 0;
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (reg_wen_o !== ready_o) wen_bad++;
      if (ready_o) begin
        seen = 1'b1; res = result_o; rdo = rd_addr_o; rdy_idx = i; start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0; start_i = 1'b1; op_i = OpDivu;
    dividend_i = 32'd5; divisor_i = 32'd0; rd_addr_i = 5'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
    checks++; if (reg_wen_o !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", reg_wen_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rd_addr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    run_div(OpDivu, 32'd100, 32'd7, 5'd5, seen, res, rdo, bn, ri, wb);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL divu_seen got %b want 1", seen); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_q got %0d want 14", res); end
    checks++; if (rdo !== 5'd5) begin errors++; $display("FAIL divu_rd got %0d want 5", rdo); end
    checks++; if (bn != 33) begin errors++; $display("FAIL divu_busy got %0d want 33", bn); end
    checks++; if (ri != 33) begin errors++; $display("FAIL divu_latency got %0d want 33", ri); end
    checks++; if (wb != 0) begin errors++; $display("FAIL divu_wen_eq got %0d want 0", wb); end
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL divu_pulse got %b want 0", ready_o); end
    checks++; if (result_o !== 32'd14) begin errors++; $display("FAIL divu_hold got %0d want 14", result_o); end
    checks++; if (rd_addr_o !== 5'd5) begin errors++; $display("FAIL divu_rd_hold got %0d want 5", rd_addr_o); end
    @(posedge clk); #1;
    run_div(OpRemu, 32'd100, 32'd7, 5'd5, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu got %0d want 2", res); end
    checks++; if (ri != 33) begin errors++; $display("FAIL remu_latency got %0d want 33", ri); end
  endtask

  task automatic test_signed();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    run_div(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd3, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", res); end
    checks++; if (bn != 33) begin errors++; $display("FAIL div_neg_busy got %0d want 33", bn); end
    run_div(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd3, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", res); end
    run_div(OpDiv, 32'd20, 32'hFFFF_FFFA, 5'd11, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb got %h want fffffffd", res); end
    run_div(OpRem, 32'd20, 32'hFFFF_FFFA, 5'd11, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_negb got %h want 2", res); end
  endtask

  task automatic test_div_zero();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    run_div(OpDivu, 32'd5, 32'd0, 5'd6, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_q got %h want ffffffff", res); end
    checks++; if (ri != 1) begin errors++; $display("FAIL divz_latency got %0d want 1", ri); end
    checks++; if (bn != 1) begin errors++; $display("FAIL divz_busy got %0d want 1", bn); end
    checks++; if (rdo !== 5'd6) begin errors++; $display("FAIL divz_rd got %0d want 6", rdo); end
    run_div(OpRem, 32'd5, 32'd0, 5'd6, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL remz got %h want 5", res); end
  endtask

  task automatic test_overflow();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    run_div(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got %h want 80000000", res); end
    checks++; if (ri != 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", ri); end
    run_div(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL ovf_r got %h want 0", res); end
    // Same bits unsigned is an ordinary long division: 0x80000000 / 0xFFFFFFFF = 0.
    run_div(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL ovf_u got %h want 0", res); end
    checks++; if (ri != 33) begin errors++; $display("FAIL ovf_u_latency got %0d want 33", ri); end
  endtask

  task automatic test_flush();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    logic busy_after; int n_rdy;
    op_i = OpDivu; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd4; start_i = 1'b1;
    @(posedge clk); #1;             // E0 accepted, first CALC cycle
    repeat (9) @(posedge clk);
    #1;                             // tenth CALC cycle
    flush_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b0;
    busy_after = 1'b1; n_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) busy_after = busy_o;
      if (ready_o || reg_wen_o) n_rdy++;
    end
    @(posedge clk); #1;
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy_after); end
    checks++; if (n_rdy != 0) begin errors++; $display("FAIL flush_ready got %0d want 0", n_rdy); end
    run_div(OpDivu, 32'd9, 32'd3, 5'd7, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL flush_next got %0d want 3", res); end
    checks++; if (rdo !== 5'd7) begin errors++; $display("FAIL flush_next_rd got %0d want 7", rdo); end
  endtask

  task automatic test_flush_done();
    op_i = OpDivu; dividend_i = 32'd5; divisor_i = 32'd0; rd_addr_i = 5'd10; start_i = 1'b1;
    @(posedge clk); #1;             // shortcut: now in DONE
    start_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_done_ready got %b want 0", ready_o); end
    checks++; if (reg_wen_o !== 1'b0) begin errors++; $display("FAIL flush_done_wen got %b want 0", reg_wen_o); end
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb; int n_rdy;
    op_i = OpDivu; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd12; start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", ready_o); end
    checks++; if (reg_wen_o !== 1'b0) begin errors++; $display("FAIL rstmid_wen got %b want 0", reg_wen_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result_o); end
    checks++; if (rd_addr_o !== 5'd0) begin errors++; $display("FAIL rstmid_rd got %0d want 0", rd_addr_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_o); end
    n_rdy = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (ready_o || busy_o) n_rdy++;
    end
    checks++; if (n_rdy != 0) begin errors++; $display("FAIL rstmid_quiet got %0d want 0", n_rdy); end
    @(posedge clk); #1;
    run_div(OpDivu, 32'd8, 32'd2, 5'd2, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd4) begin errors++; $display("FAIL rstmid_next got %0d want 4", res); end
  endtask

  task automatic test_back_to_back();
    logic seen; logic [31:0] res; logic [4:0] rdo; int bn, ri, wb;
    run_div(OpDivu, 32'hFFFF_FFFF, 32'd16, 5'd1, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("FAIL b2b_first got %h want 0fffffff", res); end
    run_div(OpRemu, 32'hFFFF_FFFF, 32'd16, 5'd31, seen, res, rdo, bn, ri, wb);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL b2b_second got %h want f", res); end
    checks++; if (rdo !== 5'd31) begin errors++; $display("FAIL b2b_rd got %0d want 31", rdo); end
    checks++; if (ri != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", ri); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
